cpu816_bus_initiator: RTL and testbench

Synthesisable 65C816 bus-cycle initiator for bench and FPGA bring-up of the level-1b CPLD, replacing the physical CPU. It turns a valid/ready transaction request into a multiplexed 65816 bus cycle: bank byte on the data bus during PHI1, address, VDA/VPA/RNW and write data or read sampling during PHI2, with RDY wait-state stretching. It generates `cpu_phi2` from `hsclk` and returns read data through a one-cycle response strobe.

---
 rtl/cpu816_bus_if.sv | 38 +++
 rtl/cpu816_bus_initiator.sv | 180 ++++++++++++++++++
 tb/tb_cpu816_bus_initiator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu816_bus_if.sv
// Bundles the request/response handshake and the multiplexed 65816 bus pins.
// The initiator uses the master modport. The bench, standing in for the
// requester and the CPLD, uses the slave modport.
interface cpu816_bus_if;
  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_adr;
  logic        req_rnw;
  logic [7:0]  req_wdata;
  logic [2:0]  req_kind;
  // Response channel
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  // 65816 bus pins
  logic        cpu_phi2;
  logic [15:0] cpu_adr;
  logic        cpu_vda;
  logic        cpu_vpa;
  logic        cpu_vpb;
  logic        cpu_rnw;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_adr, req_rnw, req_wdata, req_kind, cpu_data_in, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, cpu_phi2, cpu_adr, cpu_vda, cpu_vpa,
           cpu_vpb, cpu_rnw, cpu_data_out, cpu_data_oe
  );

  modport slave (
    output req_valid, req_adr, req_rnw, req_wdata, req_kind, cpu_data_in, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, cpu_phi2, cpu_adr, cpu_vda, cpu_vpa,
           cpu_vpb, cpu_rnw, cpu_data_out, cpu_data_oe
  );
endinterface

// File: rtl/cpu816_bus_initiator.sv
// 65C816 bus-cycle initiator. It replaces the physical CPU when the level-1b
// CPLD is brought up. A free-running PH1/PH2/WAIT sequencer generates
// cpu_phi2 from hsclk. A request accepted on the final tick of one bus cycle
// becomes the next bus cycle. When no request is accepted, an internal filler
// cycle runs instead.
module cpu816_bus_initiator #(
  parameter int PHI1_TICKS = 3,
  parameter int PHI2_TICKS = 3
) (
  input  logic                 hsclk,
  input  logic                 reset,
  cpu816_bus_if.master         bus
);

  localparam int MAX_TICKS = (PHI1_TICKS > PHI2_TICKS) ? PHI1_TICKS : PHI2_TICKS;
  localparam int CW        = $clog2(MAX_TICKS);
  localparam logic [CW-1:0] LAST1 = CW'(PHI1_TICKS - 1);
  localparam logic [CW-1:0] LAST2 = CW'(PHI2_TICKS - 1);

  typedef enum logic [1:0] {PH1, PH2, WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_final;   // last hsclk of the current bus cycle
  logic          w_accept;

  logic          r_phi2;
  logic [15:0]   r_adr;
  logic          r_vda, r_vpa, r_vpb, r_rnw;
  logic [7:0]    r_dout;
  logic          r_oe;
  logic [7:0]    r_bank;    // bank byte of the cycle in flight (0 for filler)
  logic [7:0]    r_wdata;
  logic          r_active;  // cycle in flight came from an accepted request
  logic          r_rsp_valid;
  logic [7:0]    r_rdata;

  logic          w_vda, w_vpa, w_vpb;

  // Phase state and tick counter register
  always_ff @(posedge hsclk) begin
    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever the order of the statements.
    if (reset) begin
      r_state <= PH1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next phase: PH1 -> PH2 -> WAIT* -> PH1. bus_rdy matters only on the last PH2 tick and in WAIT.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first.
    // A path that leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_final     = 1'b0;
    case (r_state)
      PH1: begin
        if (r_cnt == LAST1) begin
          w_state_nxt = PH2;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PH2: begin
        if (r_cnt == LAST2) begin
          w_cnt_nxt = '0;
          if (bus.bus_rdy) begin
            w_state_nxt = PH1;
            w_final     = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (bus.bus_rdy) begin
          w_state_nxt = PH1;
          w_final     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = PH1;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Cycle-type decode of the offered request; kinds 5-7 behave as internal
  always_comb begin
    w_vda = 1'b0;
    w_vpa = 1'b0;
    w_vpb = 1'b1;
    case (bus.req_kind)
      3'd1: w_vda = 1'b1;
      3'd2: w_vpa = 1'b1;
      3'd3: begin w_vda = 1'b1; w_vpa = 1'b1; end
      3'd4: begin w_vda = 1'b1; w_vpb = 1'b0; end
      default: ;
    endcase
  end

  assign w_accept = w_final & bus.req_valid & ~reset;

  // Bus pins, data-bus multiplexing and the response channel
  always_ff @(posedge hsclk) begin
    if (reset) begin
      r_phi2      <= 1'b0;
      r_adr       <= '0;
      r_vda       <= 1'b0;
      r_vpa       <= 1'b0;
      r_vpb       <= 1'b1;
      r_rnw       <= 1'b1;
      r_dout      <= '0;
      r_oe        <= 1'b0;
      r_bank      <= '0;
      r_wdata     <= '0;
      r_active    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_phi2      <= (w_state_nxt != PH1);
      r_rsp_valid <= 1'b0;

      if (w_final) begin
        // Retire the cycle in flight and load the next one for PH1 tick 0.
        r_rsp_valid <= r_active;
        if (r_active && r_rnw) r_rdata <= bus.cpu_data_in;
        r_active    <= w_accept;
        if (w_accept) begin
          r_adr   <= bus.req_adr[15:0];
          r_vda   <= w_vda;
          r_vpa   <= w_vpa;
          r_vpb   <= w_vpb;
          r_rnw   <= bus.req_rnw;
          r_bank  <= bus.req_adr[23:16];
          r_wdata <= bus.req_wdata;
        end else begin
          // Filler cycle: the address holds and the bank byte is zero.
          r_vda   <= 1'b0;
          r_vpa   <= 1'b0;
          r_vpb   <= 1'b1;
          r_rnw   <= 1'b1;
          r_bank  <= '0;
        end
      end

      // Write data is held through PH1 tick 0. The bank byte goes out from tick 1 on.
      if (r_state == PH1 && r_cnt == '0) begin
        r_oe   <= 1'b1;
        r_dout <= r_bank;
      end

      // Entering PH2: drive write data, or release the bus for a read.
      if (r_state == PH1 && r_cnt == LAST1) begin
        r_oe <= ~r_rnw;
        if (!r_rnw) r_dout <= r_wdata;
      end
    end
  end

  assign bus.req_ready    = w_final & ~reset;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rdata;
  assign bus.cpu_phi2     = r_phi2;
  assign bus.cpu_adr      = r_adr;
  assign bus.cpu_vda      = r_vda;
  assign bus.cpu_vpa      = r_vpa;
  assign bus.cpu_vpb      = r_vpb;
  assign bus.cpu_rnw      = r_rnw;
  assign bus.cpu_data_out = r_dout;
  assign bus.cpu_data_oe  = r_oe;

endmodule

// File: tb/tb_cpu816_bus_initiator.sv
// Self-checking bench for cpu816_bus_initiator. A transaction-level model
// describes each bus cycle as a tick index 0..N-1, where N = PHI1+PHI2+waits.
// From that index and the cycle's request, the model derives every pin value.
module tb_cpu816_bus_initiator;

  localparam int P1 = 3;
  localparam int P2 = 3;

  logic hsclk = 1'b0;
  logic reset = 1'b1;

  cpu816_bus_if bus ();

  cpu816_bus_initiator #(.PHI1_TICKS(P1), .PHI2_TICKS(P2)) dut (
    .hsclk (hsclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 hsclk = ~hsclk;

  typedef struct packed {
    logic        valid;
    logic [2:0]  kind;
    logic [23:0] adr;
    logic        rnw;
    logic [7:0]  wdata;
  } cyc_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  cyc_t        cur;         // bus cycle currently on the pins
  logic        prev_valid;  // previous cycle was an accepted request
  logic [15:0] m_adr;
  logic [7:0]  m_dout;
  logic        m_oe;
  logic [7:0]  m_rdata;

  logic [2:0]  s_kind [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic v, input logic [2:0] k, input logic [23:0] a,
                              input logic r, input logic [7:0] w);
    cyc_t c;
    c.valid = v; c.kind = k; c.adr = a; c.rnw = r; c.wdata = w;
    return c;
  endfunction

  // {vda, vpa, vpb} for a bus cycle, from the cycle-type table
  function automatic logic [2:0] sig_of(input cyc_t c);
    if (!c.valid) return 3'b001;
    case (c.kind)
      3'd1:    return 3'b101;
      3'd2:    return 3'b011;
      3'd3:    return 3'b111;
      3'd4:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic cyc_t filler();
    return mk(1'b0, 3'd0, 24'h0, 1'b1, 8'h00);
  endfunction

  task automatic model_reset();
    cur = filler(); prev_valid = 1'b0;
    m_adr = '0; m_dout = '0; m_oe = 1'b0; m_rdata = '0;
  endtask

  // Hold reset for n ticks. Every tick must show the reset values.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge hsclk); #1;
      reset = 1'b1;
      bus.req_valid = 1'($urandom);
      bus.bus_rdy   = 1'($urandom);
      #1;
      check("rst_phi2",  bus.cpu_phi2, 0);
      check("rst_adr",   bus.cpu_adr, 0);
      check("rst_sig",   {bus.cpu_vda, bus.cpu_vpa, bus.cpu_vpb, bus.cpu_rnw}, 4'b0011);
      check("rst_dout",  bus.cpu_data_out, 0);
      check("rst_oe",    bus.cpu_data_oe, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_rspv",  bus.rsp_valid, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
    end
    model_reset();
  endtask

  // Run the current bus cycle with `waits` RDY wait ticks while offering nxt.
  // If abort_at >= 0, reset is raised on that tick and the cycle is abandoned.
  task automatic run_cycle(input cyc_t nxt, input int waits, input int abort_at);
    int n;
    logic wr;
    n  = P1 + P2 + waits;
    wr = cur.valid && !cur.rnw;
    if (cur.valid) m_adr = cur.adr[15:0];
    for (int i = 0; i < n; i++) begin
      @(posedge hsclk); #1;
      reset           = (i == abort_at);
      bus.req_valid   = nxt.valid;
      bus.req_kind    = nxt.kind;
      bus.req_adr     = nxt.adr;
      bus.req_rnw     = nxt.rnw;
      bus.req_wdata   = nxt.wdata;
      bus.cpu_data_in = 8'($urandom);
      if (i < P1 + P2 - 1) bus.bus_rdy = 1'($urandom);   // ignored before the last PH2 tick
      else                 bus.bus_rdy = (i == n - 1);
      if (i == 1) begin
        m_oe   = 1'b1;
        m_dout = cur.valid ? cur.adr[23:16] : 8'h00;
      end
      if (i == P1) begin
        m_oe = wr;
        if (wr) m_dout = cur.wdata;
      end
      #1;
      check("phi2",  bus.cpu_phi2, i >= P1);
      check("adr",   bus.cpu_adr, m_adr);
      check("vda_vpa_vpb", {bus.cpu_vda, bus.cpu_vpa, bus.cpu_vpb}, sig_of(cur));
      check("rnw",   bus.cpu_rnw, cur.valid ? cur.rnw : 1'b1);
      check("oe",    bus.cpu_data_oe, m_oe);
      if (m_oe) check("dout", bus.cpu_data_out, m_dout);
      check("req_ready", bus.req_ready, (i == n - 1) && (i != abort_at));
      check("rsp_valid", bus.rsp_valid, (i == 0) && prev_valid);
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
      if (i == abort_at) return;
      if (i == n - 1 && cur.valid && cur.rnw) m_rdata = bus.cpu_data_in;
    end
    prev_valid = cur.valid;
    cur        = nxt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_t q;
    bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_adr = '0;
    bus.req_rnw = 1'b1; bus.req_wdata = '0; bus.cpu_data_in = '0; bus.bus_rdy = 1'b1;
    model_reset();

    // Reset, then idle filler cycles: a 3-low / 3-high square wave with no responses
    do_reset(3);
    run_cycle(filler(), 0, -1);
    run_cycle(filler(), 0, -1);

    // Directed write, then its response
    run_cycle(mk(1'b1, 3'd1, 24'hFF8003, 1'b0, 8'h55), 0, -1);
    run_cycle(filler(), 0, -1);
    run_cycle(filler(), 0, -1);

    // Directed opcode read
    run_cycle(mk(1'b1, 3'd3, 24'h00FE30, 1'b1, 8'h00), 0, -1);
    run_cycle(filler(), 0, -1);
    run_cycle(filler(), 0, -1);

    // Read stretched by 4 RDY wait ticks
    run_cycle(mk(1'b1, 3'd1, 24'h12ABCD, 1'b1, 8'h00), 0, -1);
    run_cycle(filler(), 4, -1);
    run_cycle(filler(), 0, -1);

    // Eight back-to-back mixed requests, including a vector pull and kind 6
    s_kind = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd3, 3'd0, 3'd4, 3'd1};
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) q = mk(1'b1, s_kind[k], 24'($urandom), 1'($urandom), 8'($urandom));
      else       q = filler();
      run_cycle(q, (k == 0) ? 0 : int'($urandom_range(0, 2)), -1);
    end
    run_cycle(filler(), 0, -1);

    // Random mix of requests, gaps and wait states
    for (int k = 0; k < 20; k++) begin
      q = mk(1'($urandom), 3'($urandom_range(0, 7)), 24'($urandom), 1'($urandom), 8'($urandom));
      run_cycle(q, int'($urandom_range(0, 3)), -1);
    end
    run_cycle(filler(), 0, -1);

    // Reset raised during PH2 of a write: the cycle is abandoned and no response follows
    run_cycle(mk(1'b1, 3'd1, 24'h7E1234, 1'b0, 8'hC3), 0, -1);
    run_cycle(filler(), 0, P1 + 1);
    do_reset(2);
    run_cycle(filler(), 0, -1);
    run_cycle(filler(), 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
